// File: rtl/stopwatch_uart_reporter.sv
// Formats a snapshot of the stopwatch time as "HH:MM:SS.CC" (optionally CR/LF)
// and streams it byte by byte into a UART transmitter over a start/done handshake.
module stopwatch_uart_reporter #(
   parameter bit SEND_CRLF = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_send,
   input  logic [6:0] msec,
   input  logic [5:0] sec,
   input  logic [5:0] min,
   input  logic [4:0] hour,
   input  logic       tx_busy,
   input  logic       tx_done,
   output logic [7:0] tx_data,
   output logic       tx_start,
   output logic       o_busy,
   output logic       o_done
);

   typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

   localparam logic [3:0] LAST = SEND_CRLF ? 4'd12 : 4'd10;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] idx;
   logic [4:0] snap_hour;
   logic [5:0] snap_min;
   logic [5:0] snap_sec;
   logic [6:0] snap_msec;
   logic [7:0] cur_byte;

   // Two-digit fields cannot show more than 99; anything wider saturates there.
   function automatic logic [6:0] sat99(input logic [6:0] v);
      return (v > 7'd99) ? 7'd99 : v;
   endfunction

   function automatic logic [7:0] tens_ascii(input logic [6:0] v);
      return 8'h30 + 8'(sat99(v) / 7'd10);
   endfunction

   function automatic logic [7:0] ones_ascii(input logic [6:0] v);
      return 8'h30 + 8'(sat99(v) % 7'd10);
   endfunction

   always_comb begin
      cur_byte = 8'h00;
      case (idx)
         4'd0:    cur_byte = tens_ascii({2'b00, snap_hour});
         4'd1:    cur_byte = ones_ascii({2'b00, snap_hour});
         4'd2:    cur_byte = 8'h3A;
         4'd3:    cur_byte = tens_ascii({1'b0, snap_min});
         4'd4:    cur_byte = ones_ascii({1'b0, snap_min});
         4'd5:    cur_byte = 8'h3A;
         4'd6:    cur_byte = tens_ascii({1'b0, snap_sec});
         4'd7:    cur_byte = ones_ascii({1'b0, snap_sec});
         4'd8:    cur_byte = 8'h2E;
         4'd9:    cur_byte = tens_ascii(snap_msec);
         4'd10:   cur_byte = ones_ascii(snap_msec);
         4'd11:   cur_byte = 8'h0D;
         4'd12:   cur_byte = 8'h0A;
         default: cur_byte = 8'h00;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_send) state_nxt = SEND;
         SEND:    if (!tx_busy) state_nxt = WAIT;
         WAIT:    if (tx_done) state_nxt = (idx == LAST) ? DONE : SEND;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // tx_start and o_done default low every cycle so each is a single-cycle pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx       <= 4'd0;
         tx_data   <= 8'h00;
         tx_start  <= 1'b0;
         o_done    <= 1'b0;
         snap_hour <= 5'd0;
         snap_min  <= 6'd0;
         snap_sec  <= 6'd0;
         snap_msec <= 7'd0;
      end else begin
         tx_start <= 1'b0;
         o_done   <= 1'b0;
         case (state)
            IDLE: begin
               if (i_send) begin
                  snap_hour <= hour;
                  snap_min  <= min;
                  snap_sec  <= sec;
                  snap_msec <= msec;
                  idx       <= 4'd0;
               end
            end
            SEND: begin
               if (!tx_busy) begin
                  tx_start <= 1'b1;
                  tx_data  <= cur_byte;
               end
            end
            WAIT: begin
               if (tx_done && (idx != LAST)) idx <= idx + 4'd1;
            end
            DONE: o_done <= 1'b1;
            default: ;
         endcase
      end
   end

   assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_stopwatch_uart_reporter.sv
// Bench for stopwatch_uart_reporter: a CR/LF and a no-CR/LF instance run side by side,
// each answered by a UART TX model, with frames compared against a formatted-string model.
module tb_stopwatch_uart_reporter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       i_send;
   logic [6:0] msec;
   logic [5:0] sec;
   logic [5:0] min;
   logic [4:0] hour;
   logic       force_busy;
   logic       inj_done;

   logic       busy_m   [2];
   logic       done_m   [2];
   logic       tx_busy  [2];
   logic       tx_done  [2];
   logic       tx_start [2];
   logic       o_busy   [2];
   logic       o_done   [2];
   logic [7:0] tx_data  [2];
   logic       prev_start [2];
   logic       prev_done  [2];
   int         cnt   [2];
   int         ndone [2];

   logic [7:0] cap0 [$];
   logic [7:0] cap1 [$];

   int checks   = 0;
   int failures = 0;
   int dmin = 10;
   int dmax = 10;

   assign tx_busy[0] = busy_m[0] | force_busy;
   assign tx_busy[1] = busy_m[1] | force_busy;
   assign tx_done[0] = done_m[0] | inj_done;
   assign tx_done[1] = done_m[1] | inj_done;

   stopwatch_uart_reporter #(.SEND_CRLF(1'b0)) dut_n (
      .clk(clk), .rst(rst), .i_send(i_send), .msec(msec), .sec(sec), .min(min), .hour(hour),
      .tx_busy(tx_busy[0]), .tx_done(tx_done[0]), .tx_data(tx_data[0]), .tx_start(tx_start[0]),
      .o_busy(o_busy[0]), .o_done(o_done[0])
   );

   stopwatch_uart_reporter #(.SEND_CRLF(1'b1)) dut_c (
      .clk(clk), .rst(rst), .i_send(i_send), .msec(msec), .sec(sec), .min(min), .hour(hour),
      .tx_busy(tx_busy[1]), .tx_done(tx_done[1]), .tx_data(tx_data[1]), .tx_start(tx_start[1]),
      .o_busy(o_busy[1]), .o_done(o_done[1])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v > 99) ? 99 : v;
   endfunction

   function automatic string model(input int h, input int m, input int s, input int c, input bit crlf);
      string r;
      r = $sformatf("%02d:%02d:%02d.%02d", sat(h), sat(m), sat(s), sat(c));
      if (crlf) r = $sformatf("%s%c%c", r, 8'h0D, 8'h0A);
      return r;
   endfunction

   // UART TX model: captures each started byte, stays busy, then pulses tx_done.
   initial begin
      for (int k = 0; k < 2; k++) begin
         busy_m[k] = 1'b0; done_m[k] = 1'b0; cnt[k] = -1;
         prev_start[k] = 1'b0; prev_done[k] = 1'b0; ndone[k] = 0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            done_m[k] = 1'b0;
            if (rst) begin
               busy_m[k] = 1'b0; cnt[k] = -1; prev_start[k] = 1'b0; prev_done[k] = 1'b0;
            end else begin
               if (tx_start[k]) begin
                  check($sformatf("start_width%0d", k), prev_start[k], 1'b0);
                  check($sformatf("start_while_busy%0d", k), busy_m[k], 1'b0);
                  if (k == 0) cap0.push_back(tx_data[k]);
                  else        cap1.push_back(tx_data[k]);
                  busy_m[k] = 1'b1;
                  cnt[k] = $urandom_range(dmax, dmin);
               end
               if (cnt[k] == 0) begin
                  done_m[k] = 1'b1; busy_m[k] = 1'b0; cnt[k] = -1;
               end else if (cnt[k] > 0) begin
                  cnt[k]--;
               end
               if (o_done[k]) begin
                  ndone[k]++;
                  check($sformatf("done_width%0d", k), prev_done[k], 1'b0);
               end
               prev_start[k] = tx_start[k];
               prev_done[k]  = o_done[k];
            end
         end
      end
   end

   // mode 0: plain frame; 1: inputs change after byte 3; 2: tx_busy held, spurious done, retrigger
   task automatic run_frame(input int h, input int m, input int s, input int c, input int mode);
      string e0, e1;
      int    guard;
      bit    changed, resent;
      e0 = model(h, m, s, c, 1'b0);
      e1 = model(h, m, s, c, 1'b1);
      cap0.delete(); cap1.delete();
      ndone[0] = 0; ndone[1] = 0;
      changed = 1'b0; resent = 1'b0;
      @(negedge clk);
      hour = 5'(h); min = 6'(m); sec = 6'(s); msec = 7'(c);
      force_busy = (mode == 2);
      i_send = 1'b1;
      @(negedge clk);
      i_send = 1'b0;
      if (mode == 2) begin
         repeat (10) @(negedge clk);
         inj_done = 1'b1;
         @(negedge clk);
         inj_done = 1'b0;
         repeat (9) @(negedge clk);
         check("hold_nostart_crlf", cap1.size(), 0);
         check("hold_nostart_nocrlf", cap0.size(), 0);
         check("hold_obusy", o_busy[1], 1'b1);
         force_busy = 1'b0;
      end
      guard = 0;
      while ((o_busy[0] || o_busy[1]) && guard < 3000) begin
         @(negedge clk);
         guard++;
         if (mode == 1 && !changed && cap1.size() >= 3) begin
            hour = 5'd10; min = 6'd20; sec = 6'd30; msec = 7'd40;
            changed = 1'b1;
         end
         if (mode == 2 && !resent && cap1.size() >= 5) begin
            i_send = 1'b1;
            @(negedge clk);
            i_send = 1'b0;
            resent = 1'b1;
         end
      end
      check("frame_timeout", (guard < 3000), 1'b1);
      repeat (10) @(negedge clk);
      inj_done = 1'b1;
      @(negedge clk);
      inj_done = 1'b0;
      repeat (20) @(negedge clk);
      check("len_crlf", cap1.size(), e1.len());
      check("len_nocrlf", cap0.size(), e0.len());
      for (int i = 0; i < e1.len() && i < cap1.size(); i++)
         check($sformatf("byte%0d_crlf", i), cap1[i], e1[i]);
      for (int i = 0; i < e0.len() && i < cap0.size(); i++)
         check($sformatf("byte%0d_nocrlf", i), cap0[i], e0[i]);
      check("ndone_crlf", ndone[1], 1);
      check("ndone_nocrlf", ndone[0], 1);
      check("idle_after_crlf", o_busy[1], 1'b0);
      check("idle_after_nocrlf", o_busy[0], 1'b0);
   endtask

   initial begin
      int guard;
      rst = 1'b1; i_send = 1'b0; force_busy = 1'b0; inj_done = 1'b0;
      hour = '0; min = '0; sec = '0; msec = '0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("rst_tx_start%0d", k), tx_start[k], 1'b0);
         check($sformatf("rst_o_busy%0d", k), o_busy[k], 1'b0);
         check($sformatf("rst_o_done%0d", k), o_done[k], 1'b0);
         check($sformatf("rst_tx_data%0d", k), tx_data[k], 8'h00);
      end
      rst = 1'b0;

      dmin = 10; dmax = 10;
      run_frame(5, 7, 42, 9, 0);
      dmin = 0; dmax = 12;
      run_frame(23, 59, 59, 99, 0);
      run_frame(0, 0, 0, 127, 0);
      run_frame(31, 63, 60, 100, 0);
      dmin = 3; dmax = 3;
      run_frame(1, 2, 3, 4, 1);
      dmin = 4; dmax = 4;
      run_frame(8, 9, 10, 11, 2);

      // Abort a frame while the sixth byte is in flight.
      dmin = 10; dmax = 10;
      cap0.delete(); cap1.delete();
      ndone[0] = 0; ndone[1] = 0;
      @(negedge clk);
      hour = 5'd12; min = 6'd34; sec = 6'd56; msec = 7'd78;
      i_send = 1'b1;
      @(negedge clk);
      i_send = 1'b0;
      guard = 0;
      while (cap1.size() < 6 && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      check("abort_reach_byte6", (guard < 1000), 1'b1);
      #2 rst = 1'b1;
      #1;
      check("abort_tx_start", tx_start[1], 1'b0);
      check("abort_o_busy_crlf", o_busy[1], 1'b0);
      check("abort_o_busy_nocrlf", o_busy[0], 1'b0);
      check("abort_tx_data", tx_data[1], 8'h00);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (25) @(negedge clk);
      check("abort_no_more_bytes", cap1.size(), 6);
      check("abort_no_done", ndone[1] + ndone[0], 0);
      check("abort_stays_idle", o_busy[1], 1'b0);
      run_frame(12, 34, 56, 78, 0);

      dmin = 0; dmax = 12;
      for (int r = 0; r < 8; r++)
         run_frame($urandom_range(31, 0), $urandom_range(63, 0),
                   $urandom_range(63, 0), $urandom_range(127, 0), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
